// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled receiver for 11-bit frames
// (start, 8 data LSB-first, parity, stop). Holds one received byte plus
// status flags for the host; a one-cycle read strobe consumes the byte.
//
// Host handshake: rxrdy is high while data holds an unread byte. A read
// pulse sampled on a clock edge clears rxrdy and all error flags from the
// next cycle on. A read coinciding with a frame delivery consumes the old
// byte, so the new byte loads with rxrdy kept high and overrun not set.
//
// rxstate exposes the receiver FSM for observation:
// 0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP, 5 BREAK.
module uart_rx (
   input  logic       mclkx16,
   input  logic       reset,
   input  logic       rx,
   input  logic       paritymode,
   input  logic       read,
   output logic [7:0] data,
   output logic       rxrdy,
   output logic       parityerr,
   output logic       framingerr,
   output logic       overrun,
   output logic [2:0] rxstate
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } state_t;

   state_t     state, state_next;
   logic       rx_m, rx_s;
   logic [3:0] cnt, cnt_next;
   logic [2:0] bitidx;
   logic [7:0] shreg;
   logic       runpar;
   logic       perr_q;
   logic       sample;
   logic       deliver;

   // The counter runs modulo 16 from the start edge, so a count of 7
   // lands mid-bit for the start bit and every following bit.
   assign sample  = (cnt == 4'd7);
   assign rxstate = state;

   // Two-flop synchronizer for the asynchronous line; idles high.
   always_ff @(posedge mclkx16) begin
      if (!reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   // Next-state, counter and delivery decode.
   always_comb begin
      state_next = state;
      deliver    = 1'b0;
      case (state)
         IDLE:   if (!rx_s) state_next = START;
         START:  if (sample) state_next = rx_s ? IDLE : DATA;
         DATA:   if (sample && (bitidx == 3'd7)) state_next = PARITY;
         PARITY: if (sample) state_next = STOP;
         STOP: begin
            if (sample) begin
               deliver    = 1'b1;
               state_next = rx_s ? IDLE : BREAK;
            end
         end
         BREAK:  if (rx_s) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      // Leaving IDLE loads 1 so that the detecting edge counts as cycle 0.
      if ((state_next == IDLE) || (state_next == BREAK))
         cnt_next = 4'd0;
      else
         cnt_next = cnt + 4'd1;
   end

   // FSM state and bit-timing counter.
   always_ff @(posedge mclkx16) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Frame assembly: shift data in LSB first, keep running parity and
   // latch the parity verdict so the stop edge only has to deliver.
   always_ff @(posedge mclkx16) begin
      if (!reset) begin
         bitidx <= 3'd0;
         shreg  <= 8'h00;
         runpar <= 1'b0;
         perr_q <= 1'b0;
      end else if (sample) begin
         case (state)
            START: begin
               bitidx <= 3'd0;
               runpar <= 1'b0;
            end
            DATA: begin
               shreg  <= {rx_s, shreg[7:1]};
               runpar <= runpar ^ rx_s;
               bitidx <= bitidx + 3'd1;
            end
            PARITY: perr_q <= (rx_s != (paritymode ^ runpar));
            default: ;
         endcase
      end
   end

   // Host-visible byte and flags; delivery wins over a plain read.
   always_ff @(posedge mclkx16) begin
      if (!reset) begin
         data       <= 8'h00;
         rxrdy      <= 1'b0;
         parityerr  <= 1'b0;
         framingerr <= 1'b0;
         overrun    <= 1'b0;
      end else if (deliver) begin
         data       <= shreg;
         rxrdy      <= 1'b1;
         parityerr  <= perr_q;
         framingerr <= !rx_s;
         overrun    <= read ? 1'b0 : (overrun | rxrdy);
      end else if (read) begin
         rxrdy      <= 1'b0;
         parityerr  <= 1'b0;
         framingerr <= 1'b0;
         overrun    <= 1'b0;
      end
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver paired with the UART transmitter on the same link: recovers 11-bit frames (start, 8 data LSB-first, parity, stop) from the `rx` line using the 16x oversampling clock. It holds one received byte plus status flags for the host, with a single-cycle read handshake. It sits between the board RX pin and the host register interface.

## Interface
Parameters: none. Frame format and oversampling ratio are fixed.
- mclkx16  in  1  16x bit-rate clock; sole clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset; sampled on mclkx16 rising edge
- rx  in  1  serial line, idle high, asynchronous to mclkx16
- paritymode  in  1  0 = even parity, 1 = odd parity (parity bit = paritymode XOR ^data)
- read  in  1  host read strobe, 1-cycle pulse, clears rxrdy and error flags
- data  out  8  last received byte
- rxrdy  out  1  high while an unread byte is held in data
- parityerr  out  1  parity mismatch on the byte in data
- framingerr  out  1  stop bit sampled low on the byte in data
- overrun  out  1  sticky; a frame completed while rxrdy was already high

## Operation
- Input path: rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s only.
- Bit timing: one bit = 16 mclkx16 cycles. A 4-bit sample counter is reused per bit.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: counter held at 0. rx_s == 0 -> START, counter starts.
- START: counter reaches 7 (mid start bit). If rx_s == 1 -> false start, return to IDLE with no flag change. Otherwise clear the bit index and go to DATA.
- DATA: sample rx_s every 16 cycles into a shift register, LSB first; the running parity accumulates each bit. After bit 7 -> PARITY.
- PARITY: sample one bit. Compare it with paritymode XOR (XOR of the 8 data bits).
- STOP: sample one bit. Every frame reaching STOP is delivered, even with errors:
  - load data
  - parityerr = mismatch
  - framingerr = (stop bit == 0)
  - overrun |= (rxrdy && !read)
  - rxrdy = 1
- Next state after STOP: IDLE if the stop bit was 1; BREAK if it was 0. BREAK waits for rx_s == 1, then goes to IDLE. A line held low produces exactly one framing-error frame.
- read (rxrdy high or low): clears rxrdy, parityerr, framingerr, overrun in the next cycle. data is unchanged.
- read in the same cycle as frame delivery: the old byte counts as consumed. The new byte loads, rxrdy stays 1, overrun is not set, and the error flags take the new frame's values.
- Overrun: the new byte overwrites data. overrun stays 1 until read.
- reset low: all state returns to IDLE and the counter to 0 on that edge. Any frame in progress is aborted. reset has priority over read and delivery.

## Timing
- Reset values: data = 8'h00, rxrdy = 0, parityerr = 0, framingerr = 0, overrun = 0, state IDLE. The synchronizer flops reset to 1.
- Cycle 0 is the first edge at which rx_s == 0 in IDLE. Sample points:
  - start check: cycle 7
  - data bit k: cycle 7 + 16(k+1)
  - parity: cycle 151
  - stop: cycle 167
- Outputs update on the cycle-167 edge. rxrdy is visible from cycle 168.
- Pin to rx_s delay is 2 cycles. Pin falling edge to rxrdy is about 170 cycles.
- After a good stop, IDLE is entered at cycle 168. A start bit immediately following (frame end to frame start, back to back) is detected. Tolerates about ±3 cycles of bit-edge skew per frame.
- read takes effect on the edge where it is sampled high; flags are low from the next cycle.

## Test plan
- Single frame, byte 8'hA5, paritymode = 0, correct parity bit 0 -> data = 8'hA5, rxrdy = 1 at cycle 168, all error flags 0; read pulse -> rxrdy = 0 next cycle.
- Same frame with paritymode = 1 and the parity bit left at 0 -> parityerr = 1, data = 8'hA5. Then 8'h00 with odd parity (bit 1) -> parityerr = 0.
- Glitch: rx low for 4 cycles only -> no rxrdy, state back to IDLE, a following valid 8'h3C is received correctly.
- Two back-to-back frames 8'h11, 8'h22 with no read -> data = 8'h22, overrun = 1. Repeat with read asserted on the cycle of the 2nd delivery -> overrun = 0, rxrdy = 1.
- Stop bit 0 on 8'hFF, then rx held low for 40 bit times -> one delivery with framingerr = 1, no further rxrdy until rx returns high and a new frame arrives.
- reset low at cycle 80 of a frame -> all outputs at reset values next cycle. The remainder of the aborted frame produces no delivery, and the next clean frame is received.
